// File: rtl/matching_cost_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matching_cost_ctrl
// Purpose  : Sequencer for the census matching-cost datapath. Accepts the
//            pre-synchronized left/right census stream over valid/ready,
//            drives the datapath enable/SOF/EOL/data inputs, and carries a
//            tag shift register that matches the datapath's fixed latency.
//            Every cost vector leaving the datapath is tagged with valid,
//            EOL, column and valid-disparity count. Each line is followed
//            by PIPE_LAT bubble beats so the line's last pixels drain out.
//            Downstream backpressure stalls the whole pipeline.
//
// Ports    : clk, rst                  clock, synchronous active-high reset
//            in_valid/in_ready         input handshake
//            in_sof/in_eol             frame start / line end markers
//            in_left/in_right          census words
//            cost_en                   datapath advance
//            cost_sof/cost_eol         markers to datapath
//            cost_left/cost_right      data to datapath (zero when not sent)
//            out_valid/out_ready       output handshake (head of tag pipe)
//            out_eol/out_col/out_ndisp output pixel tags
//            frame_done                one-cycle pulse after last line flush
//            err                       sticky protocol error
//
// Options  : MATCHING_COST_CTRL_STATS_EN adds stat_stall_cnt (32b) and
//            stat_line_cnt (COLW). Both clear on rst and accepted in_sof.
//
// Revision : 1.0 - initial release
// ============================================================================
module matching_cost_ctrl #(
    parameter int MAXDISPARITY = 64,
    parameter int INPUTDATAWID = 63,
    parameter int PIPE_LAT     = 8,
    parameter int IMG_W        = 640,
    parameter int IMG_H        = 480,
    parameter int COLW         = 10,
    parameter int DISPW        = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic                    in_eol,
    input  logic [INPUTDATAWID-1:0] in_left,
    input  logic [INPUTDATAWID-1:0] in_right,
    output logic                    cost_en,
    output logic                    cost_sof,
    output logic                    cost_eol,
    output logic [INPUTDATAWID-1:0] cost_left,
    output logic [INPUTDATAWID-1:0] cost_right,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_eol,
    output logic [COLW-1:0]         out_col,
    output logic [DISPW-1:0]        out_ndisp,
    output logic                    frame_done,
    output logic                    err
`ifdef MATCHING_COST_CTRL_STATS_EN
    ,
    output logic [31:0]             stat_stall_cnt,
    output logic [COLW-1:0]         stat_line_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_flush_w    = $clog2(PIPE_LAT + 1);
    localparam logic [c_flush_w-1:0] c_flush_init = c_flush_w'(PIPE_LAT);
    localparam logic [c_flush_w-1:0] c_flush_one  = c_flush_w'(1);
    localparam logic [COLW-1:0]     c_last_col   = COLW'(IMG_W - 1);
    localparam logic [COLW-1:0]     c_last_row   = COLW'(IMG_H - 1);
    localparam logic [COLW-1:0]     c_dmax       = COLW'(MAXDISPARITY - 1);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_run   = 2'd1;
    localparam logic [1:0] c_s_flush = 2'd2;

    typedef struct packed {
        logic             valid;
        logic             eol;
        logic [COLW-1:0]  col;
        logic [DISPW-1:0] ndisp;
    } tag_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_nx;
    logic [COLW-1:0]      r_col;
    logic [COLW-1:0]      r_row;
    logic [c_flush_w-1:0] r_flush_cnt;
    logic                 r_last_line;
    logic                 r_frame_done;
    logic                 r_err;
    tag_t                 r_tag [PIPE_LAT];

    logic                 w_adv;
    logic                 w_send;
    logic                 w_bubble;
    logic                 w_err_set;
    logic                 w_line_end;
    logic                 w_flush_last;
    logic [COLW-1:0]      w_beat_col;
    logic [COLW-1:0]      w_beat_row;
    logic [COLW-1:0]      w_ndisp_col;
    tag_t                 w_tag_in;

    // Head of the tag pipe lines up with the datapath output.
    assign out_valid  = r_tag[PIPE_LAT-1].valid;
    assign out_eol    = r_tag[PIPE_LAT-1].eol;
    assign out_col    = r_tag[PIPE_LAT-1].col;
    assign out_ndisp  = r_tag[PIPE_LAT-1].ndisp;
    assign frame_done = r_frame_done;
    assign err        = r_err;

    // A held output pixel freezes everything, including the datapath.
    assign w_adv = !(out_valid && !out_ready);

    // ------------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        w_send     = 1'b0;
        w_bubble   = 1'b0;
        w_err_set  = 1'b0;
        w_beat_col = r_col;
        w_beat_row = r_row;

        if (!rst) begin
            case (r_state)
                c_s_idle: begin
                    // Anything before a frame start is consumed and ignored.
                    in_ready = 1'b1;
                    if (in_valid && in_sof) begin
                        w_send     = 1'b1;
                        w_beat_col = '0;
                        w_beat_row = '0;
                        w_state_nx = c_s_run;
                    end
                end

                c_s_run: begin
                    in_ready = w_adv;
                    if (in_valid && w_adv) begin
                        if (in_sof) begin
                            // Unexpected frame start: restart coordinates,
                            // no flush of the partial line.
                            w_send     = 1'b1;
                            w_err_set  = 1'b1;
                            w_beat_col = '0;
                            w_beat_row = '0;
                        end else if ((r_col == c_last_col) && !in_eol) begin
                            // Over-long line: consume the beat but keep it
                            // out of the datapath.
                            w_err_set = 1'b1;
                        end else begin
                            w_send = 1'b1;
                        end
                    end
                end

                c_s_flush: begin
                    if (w_adv) begin
                        w_bubble = 1'b1;
                        if (r_flush_cnt == c_flush_one) begin
                            w_state_nx = r_last_line ? c_s_idle : c_s_run;
                        end
                    end
                end

                default: begin
                    w_state_nx = c_s_idle;
                end
            endcase

            // A line end always flushes; a short line is flagged but still
            // ends normally.
            if (w_send && in_eol) begin
                w_state_nx = c_s_flush;
                if (w_beat_col != c_last_col) begin
                    w_err_set = 1'b1;
                end
            end
        end
    end

    assign w_line_end   = w_send && in_eol;
    assign w_flush_last = w_bubble && (r_flush_cnt == c_flush_one);

    // ------------------------------------------------------------------------
    // Datapath drive (data is zeroed whenever no real beat is sent)
    // ------------------------------------------------------------------------
    assign cost_en    = w_send | w_bubble;
    assign cost_sof   = w_send & in_sof;
    assign cost_eol   = w_send & in_eol;
    assign cost_left  = w_send ? in_left  : '0;
    assign cost_right = w_send ? in_right : '0;

    // Only disparities that stay inside the line are valid at low columns.
    assign w_ndisp_col = (w_beat_col < c_dmax) ? w_beat_col : c_dmax;

    always_comb begin
        w_tag_in = '0;
        if (w_send) begin
            w_tag_in.valid = 1'b1;
            w_tag_in.eol   = in_eol;
            w_tag_in.col   = w_beat_col;
            w_tag_in.ndisp = DISPW'(w_ndisp_col) + DISPW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Position, flush and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_flush_cnt  <= '0;
            r_last_line  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= w_flush_last && r_last_line;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_send) begin
                if (in_eol) begin
                    r_col       <= '0;
                    r_row       <= w_beat_row + COLW'(1);
                    r_last_line <= (w_beat_row == c_last_row);
                    r_flush_cnt <= c_flush_init;
                end else begin
                    r_col <= w_beat_col + COLW'(1);
                    r_row <= w_beat_row;
                end
            end else if (w_bubble) begin
                r_flush_cnt <= r_flush_cnt - c_flush_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag pipe: advances in lockstep with the datapath enable
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else if (cost_en) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_tag[0] <= w_tag_in;
        end
    end

`ifdef MATCHING_COST_CTRL_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
    logic [31:0]     r_stat_stall;
    logic [COLW-1:0] r_stat_line;

    assign stat_stall_cnt = r_stat_stall;
    assign stat_line_cnt  = r_stat_line;

    always_ff @(posedge clk) begin
        if (rst || (w_send && in_sof)) begin
            r_stat_stall <= '0;
            r_stat_line  <= '0;
        end else begin
            if (!w_adv) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
            if (w_flush_last) begin
                r_stat_line <= r_stat_line + COLW'(1);
            end
        end
    end
`endif

    // Line-end flag is only needed by the decode above.
    logic w_unused;
    assign w_unused = w_line_end;

endmodule
`default_nettype wire

// File: tb/tb_matching_cost_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matching_cost_ctrl
// Purpose  : Self-checking bench for matching_cost_ctrl on a small 8x2 image
//            with D=4 and PIPE_LAT=4. A cycle table covers reset, latency,
//            stall and flush timing; frame-level sequences are checked
//            against a pixel-order reference model of the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matching_cost_ctrl;

    localparam int W     = 8;
    localparam int H     = 2;
    localparam int D     = 4;
    localparam int PL    = 4;
    localparam int DW    = 15;
    localparam int COLW  = 10;
    localparam int DISPW = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic             in_eol;
    logic [DW-1:0]    in_left;
    logic [DW-1:0]    in_right;
    logic             cost_en;
    logic             cost_sof;
    logic             cost_eol;
    logic [DW-1:0]    cost_left;
    logic [DW-1:0]    cost_right;
    logic             out_valid;
    logic             out_ready;
    logic             out_eol;
    logic [COLW-1:0]  out_col;
    logic [DISPW-1:0] out_ndisp;
    logic             frame_done;
    logic             err;
`ifdef MATCHING_COST_CTRL_STATS_EN
    logic [31:0]      stat_stall_cnt;
    logic [COLW-1:0]  stat_line_cnt;
`endif

    matching_cost_ctrl #(
        .MAXDISPARITY(D), .INPUTDATAWID(DW), .PIPE_LAT(PL),
        .IMG_W(W), .IMG_H(H), .COLW(COLW), .DISPW(DISPW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_eol(in_eol),
        .in_left(in_left), .in_right(in_right),
        .cost_en(cost_en), .cost_sof(cost_sof), .cost_eol(cost_eol),
        .cost_left(cost_left), .cost_right(cost_right),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_eol(out_eol), .out_col(out_col), .out_ndisp(out_ndisp),
        .frame_done(frame_done), .err(err)
`ifdef MATCHING_COST_CTRL_STATS_EN
        , .stat_stall_cnt(stat_stall_cnt), .stat_line_cnt(stat_line_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the ordered list of pixels a frame must produce
    // ------------------------------------------------------------------------
    typedef struct {
        int col;
        bit eol;
        int ndisp;
    } exp_t;

    exp_t expq[$];
    bit   m_active;
    int   m_col;
    int   m_row;
    bit   m_err;
    int   m_frames;

    function automatic void model_reset();
        expq.delete();
        m_active = 0;
        m_col    = 0;
        m_row    = 0;
        m_err    = 0;
        m_frames = 0;
    endfunction

    function automatic void emit(int col, bit eol);
        exp_t e;
        e.col   = col;
        e.eol   = eol;
        e.ndisp = ((col < D - 1) ? col : D - 1) + 1;
        expq.push_back(e);
    endfunction

    function automatic void end_line();
        m_col = 0;
        m_row++;
        if (m_row == H) begin
            m_active = 0;
            m_frames++;
        end
    endfunction

    function automatic void model_beat(bit sof, bit eol);
        if (!m_active) begin
            if (sof) begin
                m_active = 1;
                m_row    = 0;
                emit(0, eol);
                if (eol) begin
                    if (W != 1) m_err = 1;
                    end_line();
                end else begin
                    m_col = 1;
                end
            end
        end else if (sof) begin
            m_err = 1;
            m_row = 0;
            emit(0, eol);
            if (eol) end_line();
            else m_col = 1;
        end else if (m_col == W - 1 && !eol) begin
            m_err = 1;
        end else begin
            emit(m_col, eol);
            if (eol) begin
                if (m_col != W - 1) m_err = 1;
                end_line();
            end else begin
                m_col++;
            end
        end
    endfunction

    // ------------------------------------------------------------------------
    // Cycle engine with monitor
    // ------------------------------------------------------------------------
    bit mon_en      = 0;
    bit cont        = 1;
    int rdy_mode    = 0;
    int force_stall = 0;
    int frames_seen = 0;
    int delivered   = 0;

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (mon_en) begin
            chk("stall_gate", {31'd0, cost_en && out_valid && !out_ready}, 32'd0);
            if (cost_en) begin
                chk("cost_left",  {17'd0, cost_left},  acc ? {17'd0, in_left}  : 32'd0);
                chk("cost_right", {17'd0, cost_right}, acc ? {17'd0, in_right} : 32'd0);
            end
            if (out_valid && out_ready && cost_en) begin
                delivered++;
                if (expq.size() == 0) begin
                    chk("extra_pixel", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("out_col",   {22'd0, out_col},   e.col);
                    chk("out_eol",   {31'd0, out_eol},   {31'd0, e.eol});
                    chk("out_ndisp", {25'd0, out_ndisp}, e.ndisp);
                end
            end
            if (frame_done) frames_seen++;
            if (acc) model_beat(in_sof, in_eol);
        end
        @(posedge clk);
        #1;
        if (force_stall > 0) begin
            out_ready = 1'b0;
            force_stall--;
        end else begin
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                default: out_ready = ($urandom % 4) != 0;
            endcase
        end
    endtask

    task automatic send_beat(input bit sof, input bit eol);
        bit acc;
        int n;
        acc      = 0;
        n        = 0;
        in_sof   = sof;
        in_eol   = eol;
        in_left  = DW'($urandom);
        in_right = DW'($urandom);
        while (!acc) begin
            in_valid = cont ? 1'b1 : (($urandom % 3) != 0);
            tick(acc);
            n++;
            if (!acc && n > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                acc = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int garbage);
        for (int g = 0; g < garbage; g++) send_beat(1'b0, 1'($urandom % 2));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_beat(r == 0 && c == 0, c == W - 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n        = 0;
        in_valid = 1'b0;
        while ((frames_seen != m_frames || expq.size() != 0) && n < 300) begin
            tick(acc);
            n++;
        end
        tick(acc);
        chk("frames_done", frames_seen, m_frames);
        chk("pending_pixels", expq.size(), 32'd0);
        chk("err_flag", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        mon_en      = 0;
        force_stall = 0;
        rst         = 1'b1;
        in_valid    = 1'b1;
        in_sof      = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cost_en",  {31'd0, cost_en},  32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("post_rst_err",        {31'd0, err},        32'd0);
        chk("post_rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("post_rst_out_col",    {22'd0, out_col},    32'd0);
        chk("post_rst_in_ready",   {31'd0, in_ready},   32'd1);
        @(posedge clk);
        #1;
        model_reset();
        frames_seen = 0;
        delivered   = 0;
        mon_en      = 1;
    endtask

    // ------------------------------------------------------------------------
    // Cycle table: reset, start-of-frame latency, stall, early EOL and flush
    // ------------------------------------------------------------------------
    typedef struct {
        bit rst, v, sof, eol, ordy;
        bit e_rdy, e_en, e_ov, e_eol;
        int e_col, e_nd;
        bit e_err;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1,1,1,0,1, 0,0,0,0, 0,0, 0};
        tbl[1]  = '{0,1,0,0,1, 1,0,0,0, 0,0, 0};
        tbl[2]  = '{0,1,1,0,1, 1,1,0,0, 0,0, 0};
        tbl[3]  = '{0,1,0,0,1, 1,1,0,0, 0,0, 0};
        tbl[4]  = '{0,1,0,0,1, 1,1,0,0, 0,0, 0};
        tbl[5]  = '{0,1,0,0,1, 1,1,0,0, 0,0, 0};
        tbl[6]  = '{0,1,0,0,1, 1,1,1,0, 0,1, 0};
        tbl[7]  = '{0,1,0,0,0, 0,0,1,0, 1,2, 0};
        tbl[8]  = '{0,0,0,0,0, 0,0,1,0, 1,2, 0};
        tbl[9]  = '{0,0,0,0,1, 1,0,1,0, 1,2, 0};
        tbl[10] = '{0,1,0,1,1, 1,1,1,0, 1,2, 0};
        tbl[11] = '{0,1,0,0,1, 0,1,1,0, 2,3, 1};
        tbl[12] = '{0,1,0,0,1, 0,1,1,0, 3,4, 1};
        tbl[13] = '{0,1,0,0,1, 0,1,1,0, 4,4, 1};
        tbl[14] = '{0,1,0,0,1, 0,1,1,1, 5,4, 1};
        tbl[15] = '{0,0,0,0,1, 1,0,0,0, 0,0, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_eol    = 1'b0;
        in_left   = '0;
        in_right  = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].v;
            in_sof    = tbl[i].sof;
            in_eol    = tbl[i].eol;
            out_ready = tbl[i].ordy;
            in_left   = DW'(i + 1);
            in_right  = DW'(i + 100);
            @(negedge clk);
            chk("tbl_in_ready",  {31'd0, in_ready},  {31'd0, tbl[i].e_rdy});
            chk("tbl_cost_en",   {31'd0, cost_en},   {31'd0, tbl[i].e_en});
            chk("tbl_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk("tbl_out_eol",   {31'd0, out_eol},   {31'd0, tbl[i].e_eol});
            chk("tbl_out_col",   {22'd0, out_col},   tbl[i].e_col);
            chk("tbl_out_ndisp", {25'd0, out_ndisp}, tbl[i].e_nd);
            chk("tbl_err",       {31'd0, err},       {31'd0, tbl[i].e_err});
            @(posedge clk);
            #1;
        end

        // Clean frame, continuous input, no backpressure.
        do_reset();
        rdy_mode = 0; cont = 1;
        send_frame(0);
        drain();
        chk("frameA_pixels", delivered, W * H);
        chk("frameA_done_pulses", frames_seen, 1);

        // Same frame, out_ready toggling every cycle.
        do_reset();
        rdy_mode = 1;
        send_frame(0);
        drain();
        chk("frameB_pixels", delivered, W * H);

        // Junk beats before the first SOF are dropped.
        do_reset();
        rdy_mode = 2; cont = 0;
        send_frame(3);
        drain();

        // Early EOL at column 5 on the first line.
        do_reset();
        rdy_mode = 0; cont = 1;
        for (int c = 0; c < 6; c++) send_beat(c == 0, c == 5);
        for (int c = 0; c < W; c++) send_beat(1'b0, c == W - 1);
        drain();

        // Missing EOL: extra beat at the last column is dropped.
        do_reset();
        rdy_mode = 2;
        for (int c = 0; c < W; c++) send_beat(c == 0, 1'b0);
        send_beat(1'b0, 1'b1);
        for (int c = 0; c < W; c++) send_beat(1'b0, c == W - 1);
        drain();

        // SOF in the middle of a line restarts coordinates.
        do_reset();
        for (int c = 0; c < 3; c++) send_beat(c == 0, 1'b0);
        send_frame(0);
        drain();

        // Reset with tags in flight, then a full frame.
        do_reset();
        rdy_mode = 0;
        for (int c = 0; c < 5; c++) send_beat(c == 0, 1'b0);
        do_reset();
        send_frame(1);
        drain();

        // Randomized frames back to back.
        do_reset();
        rdy_mode = 2; cont = 0;
        for (int f = 0; f < 5; f++) begin
            send_frame($urandom_range(0, 3));
            drain();
        end

`ifdef MATCHING_COST_CTRL_STATS_EN
        // Three forced stall cycles on a two-line frame.
        do_reset();
        rdy_mode = 0; cont = 1;
        for (int c = 0; c < 6; c++) send_beat(c == 0, 1'b0);
        force_stall = 3;
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        for (int c = 0; c < W; c++) send_beat(1'b0, c == W - 1);
        drain();
        chk("stat_stall_cnt", stat_stall_cnt, 32'd3);
        chk("stat_line_cnt",  {22'd0, stat_line_cnt}, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
